// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package serial_adder_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DIGIT = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of DIGIT-wide slices needed to cover WIDTH bits.
   function automatic int num_digits(input int width, input int digit);
      return width / digit;
   endfunction

   // Digit counter width; a single-digit adder still gets a 1-bit counter.
   function automatic int count_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple-carry slice built from full-adder cells.
module digit_adder
   import serial_adder_pkg::*;
#(
   parameter int DIGIT = DEF_DIGIT
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             c_in,
   output logic [DIGIT-1:0] s_d,
   output logic             c_out
);

   // Ripple the carry through one full-adder cell per bit.
   always_comb begin
      logic [DIGIT:0] c;
      c    = '0;
      s_d  = '0;
      c[0] = c_in;
      for (int i = 0; i < DIGIT; i++) begin
         s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
         c[i+1]   = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
      end
      c_out = c[DIGIT];
   end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: adds a + b + cin DIGIT bits per clock, LSB digit first,
// with a start/busy/done handshake. The result holds in DONE until the next start.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input (a - b) and an 'ovf'
// output reporting two's-complement overflow of the finished operation.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIGIT = DEF_DIGIT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
   output logic             ovf,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT);
   localparam int CW         = count_width(NUM_DIGITS);

   if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_adder: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic [CW-1:0]    count_q;
   logic             carry_q, cout_q;
   logic             accept, last;
   logic [WIDTH-1:0] b_load, sum_shift;
   logic             c_load;
   logic [DIGIT-1:0] s_d;
   logic             slice_cout;

   assign accept = start && ((state_q == IDLE) || (state_q == DONE));
   assign last   = (count_q == CW'(NUM_DIGITS - 1));

`ifdef SERIAL_ADDER_SUB_EN
   // Subtraction is a + ~b + 1: invert B and force the initial carry.
   assign b_load = sub ? ~b : b;
   assign c_load = sub ? 1'b1 : cin;
`else
   assign b_load = b;
   assign c_load = cin;
`endif

   // New result digit enters sum from the MSB side.
   if (NUM_DIGITS == 1) begin : g_one_digit
      assign sum_shift = s_d;
   end else begin : g_many_digits
      assign sum_shift = {s_d, sum_q[WIDTH-1:DIGIT]};
   end

   digit_adder #(.DIGIT(DIGIT)) u_slice (
      .a_d   (a_q[DIGIT-1:0]),
      .b_d   (b_q[DIGIT-1:0]),
      .c_in  (carry_q),
      .s_d   (s_d),
      .c_out (slice_cout)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; start is only honoured outside RUN.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last)  state_d = DONE;
         DONE:    if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from the current state.
   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   // Operand shift registers, carry, counter and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the shift registers are plain flops, so they are cleared like any other state.
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         count_q <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b_load;
         carry_q <= c_load;
         count_q <= '0;
      end else if (state_q == RUN) begin
         a_q     <= a_q >> DIGIT;
         b_q     <= b_q >> DIGIT;
         carry_q <= slice_cout;
         sum_q   <= sum_shift;
         count_q <= count_q + CW'(1);
         if (last) cout_q <= slice_cout;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

`ifdef SERIAL_ADDER_SUB_EN
   logic ovf_q;

   // On the final digit the slice holds the operand and sum MSBs: equal operand
   // signs with a differing sum sign is signed overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if ((state_q == RUN) && last && !accept) begin
         ovf_q <= (a_q[DIGIT-1] == b_q[DIGIT-1]) && (s_d[DIGIT-1] != a_q[DIGIT-1]);
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit/1-bit-digit instance and a
// 16-bit/4-bit-digit instance, each tracked by a latency + arithmetic model.
module tb_serial_adder;

`ifdef SERIAL_ADDER_SUB_EN
   localparam bit HAS_SUB = 1'b1;
`else
   localparam bit HAS_SUB = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   logic        start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8, cout8;
   logic [7:0]  sum8;

   logic        start16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16, cout16;
   logic [15:0] sum16;

`ifdef SERIAL_ADDER_SUB_EN
   logic        ovf8, ovf16;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub8), .ovf(ovf8),
`endif
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub16), .ovf(ovf16),
`endif
      .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: returns the (w+1)-bit result, bit w being the carry out.
   function automatic int ref_res(input int w, input int a, input int b, input bit cin, input bit sub);
      int mask = (1 << w) - 1;
      if (sub) return a + ((~b) & mask) + 1;
      return a + b + int'(cin);
   endfunction

   // Signed overflow: the true signed result falls outside the w-bit range.
   function automatic bit ref_ovf(input int w, input int a, input int b, input bit cin, input bit sub);
      int half = 1 << (w - 1);
      int sa   = (a >= half) ? a - (1 << w) : a;
      int sb   = (b >= half) ? b - (1 << w) : b;
      int r    = sub ? sa - sb : sa + sb + int'(cin);
      return (r > half - 1) || (r < -half);
   endfunction

   // Models: an accepted start yields busy for N cycles, then done with the result.
   int          m8_rem = 0, p8_res = 0;
   bit          m8_busy = 0, m8_done = 0, m8_cout = 0, m8_ovf = 0, p8_ovf = 0;
   logic [7:0]  m8_sum = '0;
   int          m16_rem = 0, p16_res = 0;
   bit          m16_busy = 0, m16_done = 0, m16_cout = 0, m16_ovf = 0, p16_ovf = 0;
   logic [15:0] m16_sum = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m8_rem <= 0; m8_busy <= 0; m8_done <= 0; m8_sum <= '0; m8_cout <= 0; m8_ovf <= 0;
      end else if (m8_busy) begin
         m8_rem <= m8_rem - 1;
         if (m8_rem == 1) begin
            m8_busy <= 0; m8_done <= 1;
            m8_sum  <= p8_res[7:0]; m8_cout <= p8_res[8]; m8_ovf <= p8_ovf;
         end
      end else if (start8) begin
         p8_res  <= ref_res(8, int'(a8), int'(b8), cin8, HAS_SUB && sub8);
         p8_ovf  <= ref_ovf(8, int'(a8), int'(b8), cin8, HAS_SUB && sub8);
         m8_busy <= 1; m8_done <= 0; m8_rem <= 8;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m16_rem <= 0; m16_busy <= 0; m16_done <= 0; m16_sum <= '0; m16_cout <= 0; m16_ovf <= 0;
      end else if (m16_busy) begin
         m16_rem <= m16_rem - 1;
         if (m16_rem == 1) begin
            m16_busy <= 0; m16_done <= 1;
            m16_sum  <= p16_res[15:0]; m16_cout <= p16_res[16]; m16_ovf <= p16_ovf;
         end
      end else if (start16) begin
         p16_res  <= ref_res(16, int'(a16), int'(b16), cin16, HAS_SUB && sub16);
         p16_ovf  <= ref_ovf(16, int'(a16), int'(b16), cin16, HAS_SUB && sub16);
         m16_busy <= 1; m16_done <= 0; m16_rem <= 4;
      end
   end

   // Per-cycle compare; sum/cout/ovf only when the model says they are valid.
   always @(negedge clk) begin
      check("busy8", 32'(busy8), 32'(m8_busy));
      check("done8", 32'(done8), 32'(m8_done));
      if (!m8_busy) begin
         check("sum8", 32'(sum8), 32'(m8_sum));
         check("cout8", 32'(cout8), 32'(m8_cout));
`ifdef SERIAL_ADDER_SUB_EN
         check("ovf8", 32'(ovf8), 32'(m8_ovf));
`endif
      end
      check("busy16", 32'(busy16), 32'(m16_busy));
      check("done16", 32'(done16), 32'(m16_done));
      if (!m16_busy) begin
         check("sum16", 32'(sum16), 32'(m16_sum));
         check("cout16", 32'(cout16), 32'(m16_cout));
`ifdef SERIAL_ADDER_SUB_EN
         check("ovf16", 32'(ovf16), 32'(m16_ovf));
`endif
      end
   end

   // Called at a negedge: present a start for one cycle.
   task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
      a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
   endtask

   task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
      a16 = a; b16 = b; cin16 = c; sub16 = s; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
   endtask

   task automatic wait_done8(input string tag, input int lat);
      int k = 0;
      while (!done8 && k < 40) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_done"}, 32'(done8), 32'd1);
      check({tag, "_lat"}, 32'(k), 32'(lat));
   endtask

   task automatic wait_done16(input string tag, input int lat);
      int k = 0;
      while (!done16 && k < 40) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_done"}, 32'(done16), 32'd1);
      check({tag, "_lat"}, 32'(k), 32'(lat));
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy8", 32'(busy8), 32'd0);
      check("rst_done8", 32'(done8), 32'd0);
      check("rst_sum8", 32'(sum8), 32'd0);
      check("rst_cout8", 32'(cout8), 32'd0);
      rst_n = 1'b1;

      // 0x0F + 0x01, then hold in DONE with start low.
      go8(8'h0F, 8'h01, 1'b0, 1'b0);
      wait_done8("add0f01", 8);
      check("add0f01_sum", 32'(sum8), 32'h10);
      check("add0f01_cout", 32'(cout8), 32'd0);
      repeat (5) @(negedge clk);
      check("hold_done", 32'(done8), 32'd1);
      check("hold_sum", 32'(sum8), 32'h10);

      // Full carry chain, then a back-to-back start straight from DONE.
      go8(8'hFF, 8'hFF, 1'b1, 1'b0);
      wait_done8("addffff", 8);
      check("addffff_sum", 32'(sum8), 32'hFF);
      check("addffff_cout", 32'(cout8), 32'd1);
      go8(8'hFF, 8'h01, 1'b0, 1'b0);
      wait_done8("b2b", 8);
      check("b2b_sum", 32'(sum8), 32'h00);
      check("b2b_cout", 32'(cout8), 32'd1);

      // A start pulse during RUN must be ignored.
      go8(8'h12, 8'h34, 1'b0, 1'b0);
      @(negedge clk);
      a8 = 8'h00; b8 = 8'h00; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      wait_done8("ignore", 6);
      check("ignore_sum", 32'(sum8), 32'h46);
      check("ignore_cout", 32'(cout8), 32'd0);

      // Asynchronous reset in the middle of RUN.
      go8(8'h55, 8'hAA, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy8", 32'(busy8), 32'd0);
      check("arst_done8", 32'(done8), 32'd0);
      check("arst_sum8", 32'(sum8), 32'd0);
      check("arst_cout8", 32'(cout8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      go8(8'h01, 8'h01, 1'b0, 1'b0);
      wait_done8("post_rst", 8);
      check("post_rst_sum", 32'(sum8), 32'h02);

`ifdef SERIAL_ADDER_SUB_EN
      // Subtraction (cin ignored) and signed overflow.
      go8(8'h05, 8'h07, 1'b1, 1'b1);
      wait_done8("sub0507", 8);
      check("sub0507_sum", 32'(sum8), 32'hFE);
      check("sub0507_cout", 32'(cout8), 32'd0);
      check("sub0507_ovf", 32'(ovf8), 32'd0);
      go8(8'h80, 8'h01, 1'b0, 1'b1);
      wait_done8("sub8001", 8);
      check("sub8001_sum", 32'(sum8), 32'h7F);
      check("sub8001_cout", 32'(cout8), 32'd1);
      check("sub8001_ovf", 32'(ovf8), 32'd1);
      go8(8'h7F, 8'h01, 1'b0, 1'b0);
      wait_done8("add7f01", 8);
      check("add7f01_sum", 32'(sum8), 32'h80);
      check("add7f01_ovf", 32'(ovf8), 32'd1);
`endif

      // Short random run on the 8-bit instance.
      for (int i = 0; i < 100; i++) begin
         go8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
             HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0);
         wait_done8("rnd8", 8);
      end

      // 16-bit, 4-bit digits.
      go16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_done16("w16", 4);
      check("w16_sum", 32'(sum16), 32'h0000);
      check("w16_cout", 32'(cout16), 32'd1);
      go16(16'h1234, 16'h4321, 1'b1, 1'b0);
      wait_done16("w16b", 4);
      check("w16b_sum", 32'(sum16), 32'h5556);
      check("w16b_cout", 32'(cout16), 32'd0);

      for (int i = 0; i < 1000; i++) begin
         go16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
              HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0);
         wait_done16("rnd16", 4);
      end

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
      $fatal(1, "watchdog");
   end

endmodule
